// File: rtl/bf_pkg.sv
// bf_pkg -- shared definitions for the program fetch/decode front end.
//   op_e     : 3-bit opcode handed to the execute stage
//   CH_*     : program-ROM command characters and the end-of-program byte
//   state_e  : fetch sequencer states
package bf_pkg;

  typedef enum logic [2:0] {
    OP_INC   = 3'd0,  // '+'
    OP_DEC   = 3'd1,  // '-'
    OP_RIGHT = 3'd2,  // '>'
    OP_LEFT  = 3'd3,  // '<'
    OP_OUT   = 3'd4,  // '.'
    OP_IN    = 3'd5,  // ','
    OP_JZ    = 3'd6,  // '['
    OP_JNZ   = 3'd7   // ']'
  } op_e;

  localparam logic [7:0] CH_INC   = 8'h2B;
  localparam logic [7:0] CH_DEC   = 8'h2D;
  localparam logic [7:0] CH_RIGHT = 8'h3E;
  localparam logic [7:0] CH_LEFT  = 8'h3C;
  localparam logic [7:0] CH_OUT   = 8'h2E;
  localparam logic [7:0] CH_IN    = 8'h2C;
  localparam logic [7:0] CH_OPEN  = 8'h5B;
  localparam logic [7:0] CH_CLOSE = 8'h5D;
  localparam logic [7:0] CH_END   = 8'h00;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    PRESENT,
    SCAN_FWD,
    SCAN_BACK,
    HALT
  } state_e;

endpackage

// File: rtl/bf_decode.sv
// bf_decode -- purely combinational byte classifier.
//   data  : program-ROM byte
//   isCmd : 1 when data is one of the eight command characters
//   op    : opcode for data (OP_INC when isCmd is 0)
module bf_decode
  import bf_pkg::*;
(
  input  logic [7:0] data,
  output logic       isCmd,
  output op_e        op
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    isCmd = 1'b1;
    op    = OP_INC;
    case (data)
      CH_INC:   op = OP_INC;
      CH_DEC:   op = OP_DEC;
      CH_RIGHT: op = OP_RIGHT;
      CH_LEFT:  op = OP_LEFT;
      CH_OUT:   op = OP_OUT;
      CH_IN:    op = OP_IN;
      CH_OPEN:  op = OP_JZ;
      CH_CLOSE: op = OP_JNZ;
      default:  isCmd = 1'b0;
    endcase
  end

endmodule

// File: rtl/bf_fetch.sv
// bf_fetch -- instruction fetch sequencer for a synchronous program ROM.
//   clk        : clock, all state changes on its rising edge
//   reset      : asynchronous, active-high
//   romAddr    : ROM read address (always the internal pc)
//   romData    : ROM byte, valid the cycle after romAddr is sampled
//   instrValid : instruction offered; held with instrOp/romAddr until taken
//   instrReady : execute stage accepts (handshake = instrValid & instrReady)
//   instrOp    : opcode of the offered instruction
//   jumpTake   : on a '[' / ']' handshake, 1 = scan to the matching bracket
//   halted     : sticky, program finished or faulted
//   error      : sticky, unmatched bracket found
// Each ROM byte costs a FETCH cycle (address presented) and a DECODE cycle
// (byte evaluated); bracket scans reuse that two-cycle rhythm via scanDec.
module bf_fetch
  import bf_pkg::*;
#(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] romAddr,
  input  logic [7:0]        romData,
  output logic              instrValid,
  input  logic              instrReady,
  output logic [2:0]        instrOp,
  input  logic              jumpTake,
  output logic              halted,
  output logic              error
);

  localparam logic [ADDR_W-1:0] PC_ONE    = 1;
  localparam logic [ADDR_W:0]   DEPTH_ONE = 1;

  state_e            state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W:0]   depth;
  logic              scanDec;  // scan sub-phase: 0 = fetch byte, 1 = evaluate
  op_e               curOp;

  logic decIsCmd;
  op_e  decOp;
  logic pcMax;
  logic isOpen;
  logic isClose;

  bf_decode u_decode (
    .data  (romData),
    .isCmd (decIsCmd),
    .op    (decOp)
  );

  assign romAddr = pc;
  assign instrOp = curOp;
  assign pcMax   = &pc;
  assign isOpen  = decIsCmd && (decOp == OP_JZ);
  assign isClose = decIsCmd && (decOp == OP_JNZ);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register sees pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= FETCH;
      pc         <= '0;
      depth      <= '0;
      scanDec    <= 1'b0;
      instrValid <= 1'b0;
      curOp      <= OP_INC;
      halted     <= 1'b0;
      error      <= 1'b0;
    end else begin
      case (state)
        FETCH: state <= DECODE;

        DECODE: begin
          if (decIsCmd) begin
            curOp      <= decOp;
            instrValid <= 1'b1;
            state      <= PRESENT;
          end else if (romData == CH_END || pcMax) begin
            // end of program, or a comment byte in the last address
            state  <= HALT;
            halted <= 1'b1;
          end else begin
            pc    <= pc + PC_ONE;
            state <= FETCH;
          end
        end

        PRESENT: begin
          if (instrReady) begin
            instrValid <= 1'b0;
            scanDec    <= 1'b0;
            if (curOp == OP_JZ && jumpTake) begin
              depth <= DEPTH_ONE;
              if (pcMax) begin
                state  <= HALT;
                halted <= 1'b1;
                error  <= 1'b1;
              end else begin
                pc    <= pc + PC_ONE;
                state <= SCAN_FWD;
              end
            end else if (curOp == OP_JNZ && jumpTake) begin
              depth <= DEPTH_ONE;
              if (pc == '0) begin
                state  <= HALT;
                halted <= 1'b1;
                error  <= 1'b1;
              end else begin
                pc    <= pc - PC_ONE;
                state <= SCAN_BACK;
              end
            end else if (pcMax) begin
              // no wrap past the last address: clean end of program
              state  <= HALT;
              halted <= 1'b1;
            end else begin
              pc    <= pc + PC_ONE;
              state <= FETCH;
            end
          end
        end

        SCAN_FWD: begin
          scanDec <= ~scanDec;
          if (scanDec) begin
            if (romData == CH_END) begin
              state  <= HALT;
              halted <= 1'b1;
              error  <= 1'b1;
            end else if (isClose && depth == DEPTH_ONE) begin
              // matching ']' found: resume just after it
              depth <= '0;
              if (pcMax) begin
                state  <= HALT;
                halted <= 1'b1;
              end else begin
                pc    <= pc + PC_ONE;
                state <= FETCH;
              end
            end else begin
              if (isOpen)  depth <= depth + DEPTH_ONE;
              if (isClose) depth <= depth - DEPTH_ONE;
              if (pcMax) begin
                state  <= HALT;
                halted <= 1'b1;
                error  <= 1'b1;
              end else begin
                pc <= pc + PC_ONE;
              end
            end
          end
        end

        SCAN_BACK: begin
          scanDec <= ~scanDec;
          if (scanDec) begin
            if (isOpen && depth == DEPTH_ONE) begin
              // matching '[' found below the ']': pc+1 cannot overflow
              depth <= '0;
              pc    <= pc + PC_ONE;
              state <= FETCH;
            end else begin
              if (isClose) depth <= depth + DEPTH_ONE;
              if (isOpen)  depth <= depth - DEPTH_ONE;
              if (pc == '0) begin
                state  <= HALT;
                halted <= 1'b1;
                error  <= 1'b1;
              end else begin
                pc <= pc - PC_ONE;
              end
            end
          end
        end

        HALT: state <= HALT;

        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_bf_fetch.sv
// tb_bf_fetch -- scoreboard bench for bf_fetch.
// Stimulus tasks load a program ROM and push the expected (op, address)
// sequence into a queue; an independent monitor pops and compares on every
// handshake. jumpTake decisions come from a per-test queue consumed at each
// offered bracket.
module tb_bf_fetch;
  import bf_pkg::*;

  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [ADDR_W-1:0] romAddr;
  logic [7:0]        romData;
  logic              instrValid;
  logic              instrReady = 1'b0;
  logic [2:0]        instrOp;
  logic              jumpTake = 1'b0;
  logic              halted;
  logic              error;

  always #5 clk = ~clk;

  bf_fetch #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .romAddr    (romAddr),
    .romData    (romData),
    .instrValid (instrValid),
    .instrReady (instrReady),
    .instrOp    (instrOp),
    .jumpTake   (jumpTake),
    .halted     (halted),
    .error      (error)
  );

  // synchronous program ROM: byte appears the cycle after the address edge
  logic [7:0] rom [0:15];
  always @(posedge clk) romData <= rom[romAddr];

  typedef struct packed {
    logic [2:0]        op;
    logic [ADDR_W-1:0] addr;
  } exp_t;

  exp_t expq[$];
  bit   takeq[$];
  int   nChecks = 0;
  int   nFails  = 0;
  bit   watchGap = 1'b0;
  int   gapHits  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expect_instr(input int op, input int addr);
    expq.push_back(exp_t'{op[2:0], addr[ADDR_W-1:0]});
  endtask

  task automatic load(input string s);
    for (int i = 0; i < 16; i++) rom[i] = (i < s.len()) ? s[i] : 8'h00;
  endtask

  // monitor: samples 2 time units after the negedge, well clear of posedge
  always begin
    exp_t e;
    @(negedge clk);
    #2;
    if (!reset) begin
      if (watchGap && instrValid && (romAddr == 4'd1 || romAddr == 4'd2)) gapHits++;
      if (instrValid && instrReady) begin
        if (expq.size() == 0) begin
          nChecks++;
          nFails++;
          $display("FAIL unexpected_instr: actual op=%0d addr=%0d, expected no instruction",
                   instrOp, romAddr);
        end else begin
          e = expq.pop_front();
          check("instr_op", {29'd0, instrOp}, {29'd0, e.op});
          check("instr_addr", {28'd0, romAddr}, {28'd0, e.addr});
        end
      end
    end
  end

  // async reset pulse, checked one time unit after assertion (no clock edge)
  task automatic do_reset(input bit rdy);
    @(negedge clk);
    #1;
    reset      = 1'b1;
    jumpTake   = 1'b0;
    instrReady = 1'b0;
    #1;
    check("rst_romAddr", {28'd0, romAddr}, 32'd0);
    check("rst_instrValid", {31'd0, instrValid}, 32'd0);
    check("rst_instrOp", {29'd0, instrOp}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_error", {31'd0, error}, 32'd0);
    @(negedge clk);
    reset      = 1'b0;
    instrReady = rdy;
  endtask

  // ready held high; jumpTake taken from takeq at each offered bracket
  task automatic run(input int maxCycles, input bit expectHalt);
    instrReady = 1'b1;
    for (int c = 0; c < maxCycles; c++) begin
      @(negedge clk);
      if (halted) break;
      jumpTake = 1'b0;
      if (instrValid && (instrOp == 3'd6 || instrOp == 3'd7) && takeq.size() > 0)
        jumpTake = takeq.pop_front();
    end
    if (expectHalt) check("halted", {31'd0, halted}, 32'd1);
  endtask

  task automatic check_end(input int addr, input bit err);
    check("end_error", {31'd0, error}, {31'd0, err});
    check("end_romAddr", {28'd0, romAddr}, addr);
    check("queue_drained", expq.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "time limit reached");
  end

  initial begin
    // straight-line program, latency, end-of-program halt, absorbing HALT
    load("++>--");
    expect_instr(0, 0); expect_instr(0, 1); expect_instr(2, 2);
    expect_instr(1, 3); expect_instr(1, 4);
    do_reset(1'b1);
    @(negedge clk);
    check("latency_cycle1_valid", {31'd0, instrValid}, 32'd0);
    @(negedge clk);
    check("latency_cycle2_valid", {31'd0, instrValid}, 32'd1);
    run(40, 1'b1);
    check_end(5, 1'b0);
    repeat (3) @(negedge clk);
    check("halt_romAddr_frozen", {28'd0, romAddr}, 32'd5);
    check("halt_no_valid", {31'd0, instrValid}, 32'd0);
    check("halt_sticky", {31'd0, halted}, 32'd1);

    // back-pressure on the first instruction
    load("++>--");
    expect_instr(0, 0); expect_instr(0, 1); expect_instr(2, 2);
    expect_instr(1, 3); expect_instr(1, 4);
    do_reset(1'b0);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check("stall_valid", {31'd0, instrValid}, 32'd1);
      check("stall_op", {29'd0, instrOp}, 32'd0);
      check("stall_romAddr", {28'd0, romAddr}, 32'd0);
      @(negedge clk);
    end
    run(40, 1'b1);
    check_end(5, 1'b0);

    // comment bytes are skipped silently
    load("+a +");
    expect_instr(0, 0); expect_instr(0, 3);
    gapHits  = 0;
    watchGap = 1'b1;
    do_reset(1'b1);
    run(40, 1'b1);
    watchGap = 1'b0;
    check("comment_no_valid", gapHits, 32'd0);
    check_end(4, 1'b0);

    // forward scan over nested brackets
    load("[+[-]]>");
    takeq = '{1'b1};
    expect_instr(6, 0); expect_instr(2, 6);
    do_reset(1'b1);
    run(60, 1'b1);
    check_end(7, 1'b0);

    // '[' not taken, ']' taken once (back scan), then not taken
    load("+[-].");
    takeq = '{1'b0, 1'b1, 1'b0};
    expect_instr(0, 0); expect_instr(6, 1); expect_instr(1, 2); expect_instr(7, 3);
    expect_instr(1, 2); expect_instr(7, 3); expect_instr(4, 4);
    do_reset(1'b1);
    run(80, 1'b1);
    check_end(5, 1'b0);

    // unmatched '[' ends in an error halt
    load("[+");
    takeq = '{1'b1};
    expect_instr(6, 0);
    do_reset(1'b1);
    run(40, 1'b1);
    check_end(2, 1'b1);

    // reset in the middle of a forward scan restarts from address 0
    load("[++++++++>");
    takeq = '{1'b1};
    expect_instr(6, 0);
    do_reset(1'b1);
    run(8, 1'b0);
    check("midscan_no_valid", {31'd0, instrValid}, 32'd0);
    check("midscan_not_halted", {31'd0, halted}, 32'd0);
    check("midscan_queue", expq.size(), 32'd0);
    takeq = '{1'b0};
    expect_instr(6, 0);
    for (int a = 1; a <= 8; a++) expect_instr(0, a);
    expect_instr(2, 9);
    do_reset(1'b1);
    run(60, 1'b1);
    check_end(10, 1'b0);

    // program fills the ROM: stepping past the last address halts cleanly
    load("++++++++++++++++");
    for (int a = 0; a < 16; a++) expect_instr(0, a);
    do_reset(1'b1);
    run(80, 1'b1);
    check_end(15, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/bf_fetch.md
BF_FETCH -- requirements
Module: bf_fetch

Interface
REQ-001 SHALL have parameter ADDR_W, default 4, program-ROM address width.
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on posedge clk.
REQ-003 SHALL have port reset, input, 1; reset is asynchronous and active-high.
REQ-004 SHALL have port romAddr, output, ADDR_W, registered program-ROM read address.
REQ-005 SHALL have port romData, input, 8, ROM byte; valid the cycle after the ROM's clock edge samples romAddr.
REQ-006 SHALL have port instrValid, output, 1, decoded instruction offered to the execute stage.
REQ-007 SHALL have port instrReady, input, 1, execute stage accepts; a handshake is instrValid&instrReady at a posedge.
REQ-008 SHALL have port instrOp, output, 3, opcode: 0 '+', 1 '-', 2 '>', 3 '<', 4 '.', 5 ',', 6 '[', 7 ']'.
REQ-009 SHALL have port jumpTake, input, 1, sampled only on a handshake of op 6 or 7; ignored otherwise.
REQ-010 SHALL have ports halted and error, output, 1 each, sticky status.

Function
REQ-011 SHALL implement states FETCH, DECODE, PRESENT, SCAN_FWD, SCAN_BACK, HALT; romAddr always equals internal pc.
REQ-012 FETCH SHALL last one cycle, then go to DECODE; romData is evaluated in DECODE.
REQ-013 DECODE, command byte (0x2B,0x2D,0x3E,0x3C,0x2E,0x2C,0x5B,0x5D): SHALL latch instrOp, go to PRESENT.
REQ-014 DECODE, byte 0x00: SHALL go to HALT with error=0.
REQ-015 DECODE, any other byte: SHALL treat it as a comment, pc+1, go to FETCH; no instrValid.
REQ-016 PRESENT SHALL hold instrValid=1 with instrOp and romAddr stable until the handshake.
REQ-017 On handshake with op 6 and jumpTake=1: SHALL set depth=1, pc+1, enter SCAN_FWD.
REQ-018 On handshake with op 7 and jumpTake=1: SHALL set depth=1, pc-1, enter SCAN_BACK.
REQ-019 Any other handshake: SHALL pc+1, go to FETCH; instrValid drops the following cycle.
REQ-020 Scans SHALL use the FETCH/DECODE timing per byte; depth is ADDR_W+1 bits.
REQ-021 SCAN_FWD: '[' depth+1; ']' depth-1; at 0, pc = match+1, go to FETCH; other bytes skipped.
REQ-022 SCAN_BACK: ']' depth+1; '[' depth-1; at 0, pc = match+1, go to FETCH; other bytes skipped.
REQ-023 pc+1 from 2^ADDR_W-1 outside a scan SHALL go to HALT with error=0 (no wrap).
REQ-024 An unmatched bracket (0x00 or the address end reached in SCAN_FWD; address 0 passed in SCAN_BACK) SHALL go to HALT with error=1.
REQ-025 HALT SHALL be absorbing: halted=1, instrValid=0, romAddr frozen, until reset.
REQ-026 Minimum throughput: one instruction per 3 cycles with instrReady held high.

Reset
REQ-027 Reset SHALL immediately force state FETCH, pc=0, romAddr=0, depth=0, instrValid=0, instrOp=0, halted=0, error=0.
REQ-028 Reset asserted mid-PRESENT or mid-scan SHALL abandon the operation; fetch restarts at address 0 after release.

Structure
REQ-029 Package bf_pkg SHALL hold the opcode enum, the 8 command-character constants, the end-of-program constant 0x00 and the state enum.
REQ-030 Combinational sub-module bf_decode SHALL map byte to {isCmd, op}; all sequencing stays in bf_fetch.

Verification
REQ-031 ROM "++>--",0x00, ready=1 -> ops 0,0,2,1,1; first instrValid 2 cycles after reset release; then halted=1, error=0, romAddr=5.
REQ-032 Same ROM, instrReady=0 for 4 cycles on the first instruction -> instrValid=1, instrOp=0, romAddr=0 stable throughout.
REQ-033 ROM 0x2B,0x61,0x20,0x2B,0x00 -> exactly two op 0 handshakes; no instrValid while pc=1,2.
REQ-034 ROM "[+[-]]>",0x00, jumpTake=1 at address 0 -> next op 2 presented at romAddr=6.
REQ-035 ROM "+[-].",0x00, jumpTake=1 at the ']' (address 3) -> next op 1 at romAddr=2; jumpTake=0 there -> op 4 at romAddr=4.
REQ-036 ROM "[+",0x00, jumpTake=1 -> halted=1, error=1; reset during a SCAN_FWD -> next offered op comes from romAddr=0.
